// File: rtl/link_tx_ctrl.sv
// link_tx_ctrl: transmit-side link controller for one lane, byte clock clk_4f.
// Trains the link with COM bytes until the receiver reports active, then
// round-robin arbitrates two byte requesters onto data_tx, filling empty
// slots with IDLE. Optional periodic COM insertion during DATA is enabled
// by defining LINK_TX_PERIODIC_COM_EN.
module link_tx_ctrl #(
    parameter logic [7:0] COM_SYM      = 8'hBC,
    parameter logic [7:0] IDLE_SYM     = 8'h7C,
    parameter int         TRAIN_MIN    = 4,
    parameter int         TIMEOUT      = 64,
    parameter int         COM_INTERVAL = 32
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic       active_in,
    input  logic       req0,
    input  logic [7:0] data0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       grant0,
    output logic       grant1,
    output logic [7:0] data_tx,
    output logic       valid_tx,
    output logic       link_up,
    output logic [1:0] tx_state
);

    localparam int CW = (TRAIN_MIN > 1) ? $clog2(TRAIN_MIN) : 1;
    localparam int WW = (TIMEOUT   > 1) ? $clog2(TIMEOUT)   : 1;

    typedef enum logic [1:0] {
        S_TRAIN = 2'd0,
        S_WAIT  = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    // one transmitted byte slot
    typedef struct packed {
        logic       valid;
        logic [7:0] data;
    } tx_beat_t;

    state_t   state, state_nx;
    tx_beat_t tx_q, tx_nx;
    logic     link_q, link_nx;
    logic     rr_ptr, rr_nx;
    logic [CW-1:0] com_cnt, com_nx;
    logic [WW-1:0] wait_cnt, wait_nx;
    logic     com_slot;
    logic     gnt_ok;

`ifdef LINK_TX_PERIODIC_COM_EN
    localparam int SW = (COM_INTERVAL > 1) ? $clog2(COM_INTERVAL) : 1;
    logic [SW-1:0] skp_cnt, skp_nx;

    // a DATA cycle reserved for a COM byte; requesters are held off
    assign com_slot = (state == S_DATA) && (skp_cnt == SW'(COM_INTERVAL - 1));

    // COM spacing counter: runs in DATA, restarts on DATA entry and after each COM
    always_comb begin
        skp_nx = skp_cnt;
        if (state == S_WAIT && active_in)
            skp_nx = '0;
        else if (state == S_DATA)
            skp_nx = com_slot ? '0 : skp_cnt + SW'(1);
    end

    // skp_cnt register
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) skp_cnt <= '0;
        else        skp_cnt <= skp_nx;
    end
`else
    assign com_slot = 1'b0;
`endif

    // grants only while the link is live; the reset term keeps grants low
    // even before the asynchronous state clear is visible downstream
    assign gnt_ok = reset && (state == S_DATA) && active_in && !com_slot;

    // round-robin: a lone requester wins, on contention the one not served last
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (gnt_ok) begin
            if (req0 && req1) begin
                grant0 = rr_ptr;
                grant1 = !rr_ptr;
            end else begin
                grant0 = req0;
                grant1 = req1;
            end
        end
    end

    // next-state and next-output logic
    always_comb begin
        state_nx = state;
        tx_nx    = '{valid: 1'b0, data: COM_SYM};
        link_nx  = link_q;
        rr_nx    = rr_ptr;
        com_nx   = com_cnt;
        wait_nx  = wait_cnt;
        case (state)
            S_TRAIN: begin
                if (com_cnt == CW'(TRAIN_MIN - 1)) begin
                    state_nx = S_WAIT;
                    com_nx   = '0;
                end else begin
                    com_nx   = com_cnt + CW'(1);
                end
            end
            S_WAIT: begin
                if (active_in) begin
                    state_nx = S_DATA;
                    link_nx  = 1'b1;
                    wait_nx  = '0;
                end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                    state_nx = S_TRAIN;
                    wait_nx  = '0;
                end else begin
                    wait_nx  = wait_cnt + WW'(1);
                end
            end
            S_DATA: begin
                if (!active_in) begin
                    // link lost: retrain, keep rr_ptr
                    state_nx = S_TRAIN;
                    link_nx  = 1'b0;
                    com_nx   = '0;
                end else if (com_slot) begin
                    tx_nx = '{valid: 1'b0, data: COM_SYM};
                end else if (grant0) begin
                    tx_nx = '{valid: 1'b1, data: data0};
                    rr_nx = 1'b0;
                end else if (grant1) begin
                    tx_nx = '{valid: 1'b1, data: data1};
                    rr_nx = 1'b1;
                end else begin
                    tx_nx = '{valid: 1'b0, data: IDLE_SYM};
                end
            end
            default: begin
                state_nx = S_TRAIN;
                link_nx  = 1'b0;
                com_nx   = '0;
                wait_nx  = '0;
            end
        endcase
    end

    // state, counters and registered outputs
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            state    <= S_TRAIN;
            tx_q     <= '{valid: 1'b0, data: 8'h00};
            link_q   <= 1'b0;
            rr_ptr   <= 1'b1;
            com_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            tx_q     <= tx_nx;
            link_q   <= link_nx;
            rr_ptr   <= rr_nx;
            com_cnt  <= com_nx;
            wait_cnt <= wait_nx;
        end
    end

    assign data_tx  = tx_q.data;
    assign valid_tx = tx_q.valid;
    assign link_up  = link_q;
    assign tx_state = state;

endmodule
